scan_seq: RTL and testbench

SCAN_SEQ -- requirements
Module: scan_seq

---
 rtl/scan_seq_pkg.sv | 14 +
 rtl/scan_seq_cnt.sv | 28 ++
 rtl/scan_seq.sv | 145 ++++++++++++++
 tb/tb_scan_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared state encoding and default chain length for the scan sequencer.
package scan_seq_pkg;

  localparam int DEF_CHAIN_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/scan_seq_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement.
// Saturates at zero so a late decrement never wraps.
module scan_seq_cnt #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/scan_seq.sv
// Scan-chain sequencer: load pattern LSB first, one capture cycle, unload into Result; Done at 2*CHAIN_LEN+2.
// Start is only honoured in IDLE. Macro SCAN_SEQ_COMPARE_EN adds the ExpIn latch and Pass comparator.
module scan_seq
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 Start,
  input  logic [CHAIN_LEN-1:0] PatIn,
  input  logic [CHAIN_LEN-1:0] ExpIn,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 Busy,
  output logic                 Done,
  output logic [CHAIN_LEN-1:0] Result,
  output logic                 Pass
);

  localparam int CW = $clog2(CHAIN_LEN) + 1;

  state_t               r_state;
  logic                 r_se;
  logic                 r_si;
  logic                 r_busy;
  logic                 r_done;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_result;

  logic                 w_accept;
  logic                 w_cnt_load;
  logic                 w_cnt_dec;
  logic                 w_zero;
  logic [CHAIN_LEN-1:0] w_pat_sh;
  logic [CHAIN_LEN-1:0] w_res_nxt;

  assign w_accept   = (r_state == ST_IDLE) && Start;
  assign w_cnt_load = w_accept || (r_state == ST_CAPTURE);
  assign w_cnt_dec  = (r_state == ST_LOAD) || (r_state == ST_UNLOAD);
  assign w_pat_sh   = r_pat >> 1;
  // First unloaded bit enters at the top and ends up in Result[0].
  assign w_res_nxt  = CHAIN_LEN'({SO, r_result} >> 1);

  scan_seq_cnt #(
    .W(CW)
  ) u_cnt (
    .i_clk      (Clk),
    .i_rst_n    (Clr),
    .i_load     (w_cnt_load),
    .i_load_val (CW'(CHAIN_LEN - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state  <= ST_IDLE;
      r_se     <= 1'b0;
      r_si     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pat    <= '0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state  <= ST_LOAD;
            r_pat    <= PatIn;
            r_se     <= 1'b1;
            r_si     <= PatIn[0];
            r_busy   <= 1'b1;
            r_result <= '0;
          end
        end
        ST_LOAD: begin
          if (w_zero) begin
            r_state <= ST_CAPTURE;
            r_se    <= 1'b0;
            r_si    <= 1'b0;
          end else begin
            r_pat <= w_pat_sh;
            r_si  <= w_pat_sh[0];
          end
        end
        ST_CAPTURE: begin
          r_state <= ST_UNLOAD;
          r_se    <= 1'b1;
          r_si    <= 1'b0;
        end
        ST_UNLOAD: begin
          r_result <= w_res_nxt;
          if (w_zero) begin
            r_state <= ST_DONE;
            r_se    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_se    <= 1'b0;
          r_si    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCAN_SEQ_COMPARE_EN
  logic [CHAIN_LEN-1:0] r_exp;
  logic                 r_pass;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_exp  <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_exp  <= ExpIn;
      r_pass <= 1'b0;
    end else if ((r_state == ST_UNLOAD) && w_zero) begin
      r_pass <= (w_res_nxt == r_exp);
    end
  end

  assign Pass = r_pass;
`else
  logic w_unused_exp;
  assign w_unused_exp = ^ExpIn;
  assign Pass         = 1'b0;
`endif

  assign SE     = r_se;
  assign SI     = r_si;
  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_scan_seq.sv
// Directed bench for scan_seq with a 3-flop chain model whose functional D inputs are 3'b110.
module tb_scan_seq;

`ifdef SCAN_SEQ_COMPARE_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif
  localparam logic [2:0] CAP_D = 3'b110;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       Start;
  logic [2:0] PatIn;
  logic [2:0] ExpIn;
  logic       SO;
  logic       SE;
  logic       SI;
  logic       Busy;
  logic       Done;
  logic [2:0] Result;
  logic       Pass;
  logic [2:0] chain = 3'b000;

  int n_chk  = 0;
  int n_fail = 0;

  scan_seq #(.CHAIN_LEN(3)) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .Start  (Start),
    .PatIn  (PatIn),
    .ExpIn  (ExpIn),
    .SO     (SO),
    .SE     (SE),
    .SI     (SI),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Pass   (Pass)
  );

  always #5 Clk = ~Clk;

  // Chain model: SI enters at the top, SO leaves from bit 0; SE low captures CAP_D.
  assign SO = chain[0];
  always @(posedge Clk) begin
    if (SE) chain <= {SI, chain[2:1]};
    else    chain <= CAP_D;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] pat, input logic [2:0] exp,
                        input logic [31:0] smask, input bit wave,
                        input int n_exp_done, input int d1, input int d2, input int d3);
    int   dc [3];
    int   nd;
    logic pass_ever;
    logic exp_pass;
    dc[0] = -1; dc[1] = -1; dc[2] = -1;
    nd = 0;
    pass_ever = 1'b0;
    exp_pass = CMP_EN && (exp == CAP_D);
    PatIn = pat;
    ExpIn = exp;
    Start = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (smask[c]) begin
        Start = 1'b1;
        PatIn = 3'b000;
        ExpIn = 3'b000;
      end else begin
        Start = 1'b0;
      end
      if (Done) begin
        if (nd < 3) dc[nd] = c;
        nd++;
      end
      if (Pass) pass_ever = 1'b1;
      if (wave && c <= 9) begin
        check($sformatf("%s_se_c%0d", tag, c), SE, ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
        check($sformatf("%s_si_c%0d", tag, c), SI, (c <= 3) ? pat[c-1] : 1'b0);
        check($sformatf("%s_busy_c%0d", tag, c), Busy, (c <= 7));
        check($sformatf("%s_done_c%0d", tag, c), Done, (c == 8));
      end
      if (wave && c == 4) check($sformatf("%s_chain_loaded", tag), chain, pat);
      if (c == 8) begin
        check($sformatf("%s_result", tag), Result, CAP_D);
        check($sformatf("%s_pass", tag), Pass, exp_pass);
      end
      if (c == 9) begin
        check($sformatf("%s_result_held", tag), Result, CAP_D);
        check($sformatf("%s_pass_held", tag), Pass, exp_pass);
      end
    end
    Start = 1'b0;
    repeat (12) tick();
    check($sformatf("%s_n_done", tag), nd, n_exp_done);
    check($sformatf("%s_done1", tag), dc[0], d1);
    check($sformatf("%s_done2", tag), dc[1], d2);
    check($sformatf("%s_done3", tag), dc[2], d3);
    check($sformatf("%s_pass_seen", tag), pass_ever, exp_pass);
  endtask

  task automatic reset_mid(input string tag, input int at_c);
    int nd;
    nd = 0;
    PatIn = 3'b101;
    ExpIn = 3'b110;
    Start = 1'b1;
    for (int c = 1; c <= at_c; c++) begin
      tick();
      Start = 1'b0;
    end
    #2 Clr = 1'b0;
    #1;
    check($sformatf("%s_se", tag), SE, 1'b0);
    check($sformatf("%s_si", tag), SI, 1'b0);
    check($sformatf("%s_busy", tag), Busy, 1'b0);
    check($sformatf("%s_done", tag), Done, 1'b0);
    check($sformatf("%s_result", tag), Result, 3'b000);
    check($sformatf("%s_pass", tag), Pass, 1'b0);
    repeat (2) tick();
    Clr = 1'b1;
    repeat (14) begin
      tick();
      if (Done) nd++;
    end
    check($sformatf("%s_no_done", tag), nd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    Clr   = 1'b0;
    Start = 1'b0;
    PatIn = 3'b000;
    ExpIn = 3'b000;
    #12;
    check("rst_se", SE, 1'b0);
    check("rst_si", SI, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_result", Result, 3'b000);
    check("rst_pass", Pass, 1'b0);
    tick();
    Clr = 1'b1;
    repeat (2) tick();

    run_op("basic",    3'b101, 3'b110, 32'h0, 1'b1, 1, 8, -1, -1);
    run_op("mismatch", 3'b011, 3'b111, 32'h0, 1'b1, 1, 8, -1, -1);
    run_op("busy",     3'b101, 3'b110, (32'h1 << 2) | (32'h1 << 6) | (32'h1 << 9), 1'b0, 2, 8, 17, -1);
    reset_mid("rst_load", 2);
    run_op("post_rst", 3'b101, 3'b110, 32'h0, 1'b1, 1, 8, -1, -1);
    reset_mid("rst_unload", 7);
    run_op("b2b",      3'b101, 3'b110, 32'hFFFF_FFFF, 1'b0, 3, 8, 17, 26);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
